out_deserializer: RTL

Downstream capture stage for the serial `out` stream produced by the three-flop register/logic stage in the `clk1` domain. Hunts for a sync pattern in the incoming bit stream, locks, then assembles MSB-first words of `WIDTH` bits. Delivers them through a 2-entry buffered valid/ready interface to the consumer. Reports lock status, buffer overflow and, optionally, parity errors.

---
 rtl/out_deser_pkg.sv | 17 +
 rtl/out_deser_fifo2.sv | 56 +++++
 rtl/out_deserializer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/out_deser_pkg.sv
// Shared types and constants for the out_deserializer capture stage.
package out_deser_pkg;

   typedef enum logic {
      HUNT = 1'b0,
      LOCK = 1'b1
   } state_t;

   localparam int unsigned DEF_WIDTH = 8;
   localparam logic [31:0] DEF_SYNC  = 32'h0000_00A5;

   // Bit counter must reach WIDTH (parity slot) without wrapping.
   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w + 2);
   endfunction

endpackage

// File: rtl/out_deser_fifo2.sv
// Two-entry in-order valid/ready word buffer with registered valid/full flags.
module out_deser_fifo2 #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk1,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   output logic             full,
   input  logic             pop,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   logic [1:0]       count;
   logic [1:0]       count_nxt;
   logic [WIDTH-1:0] tail;
   logic             pop_c;
   logic             push_ok_c;

   assign pop_c     = valid && pop;
   assign push_ok_c = push && (!full || pop_c);

   always_comb begin
      count_nxt = count;
      count_nxt = count + 2'(push_ok_c) - 2'(pop_c);
   end

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         count <= 2'd0;
         valid <= 1'b0;
         full  <= 1'b0;
         data  <= '0;
         tail  <= '0;
      end else begin
         count <= count_nxt;
         valid <= (count_nxt != 2'd0);
         full  <= (count_nxt == 2'd2);
         if (pop_c && push_ok_c) begin
            if (count == 2'd1) begin
               data <= push_data;
            end else begin
               data <= tail;
               tail <= push_data;
            end
         end else if (pop_c) begin
            data <= tail;
         end else if (push_ok_c) begin
            if (count == 2'd0) data <= push_data;
            else               tail <= push_data;
         end
      end
   end

endmodule

// File: rtl/out_deserializer.sv
// Sync-hunting serial-to-word capture stage feeding a 2-entry valid/ready buffer.
// Optional even-parity frame bit is enabled by defining OUT_DESER_PARITY_EN.
module out_deserializer
   import out_deser_pkg::*;
#(
   parameter int unsigned      WIDTH        = DEF_WIDTH,
   parameter logic [WIDTH-1:0] SYNC_PATTERN = WIDTH'(DEF_SYNC)
) (
   input  logic             clk1,
   input  logic             rst_n,
   input  logic             bit_in,
   input  logic             bit_en,
   input  logic             resync,
   output logic [WIDTH-1:0] word_data,
   output logic             word_valid,
   input  logic             word_ready,
   output logic             sync_lock,
   output logic             overflow
`ifdef OUT_DESER_PARITY_EN
   ,
   output logic             parity_err
`endif
);

   localparam int unsigned CW = cnt_width(WIDTH);
`ifdef OUT_DESER_PARITY_EN
   localparam int unsigned LAST = WIDTH;
`else
   localparam int unsigned LAST = WIDTH - 1;
`endif

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] shifted_c;
   logic [WIDTH-1:0] word_c;
   logic             last_bit_c;
   logic             par_ok_c;
   logic             push_c;
   logic             full;
   logic             pop_c;

   // One register serves as sync history in HUNT and word assembler in LOCK.
   assign shifted_c  = {shreg[WIDTH-2:0], bit_in};
   assign last_bit_c = bit_en && (state == LOCK) && (cnt == CW'(LAST));
`ifdef OUT_DESER_PARITY_EN
   assign word_c     = shreg;
   assign par_ok_c   = ((^shreg) == bit_in);
`else
   assign word_c     = shifted_c;
   assign par_ok_c   = 1'b1;
`endif
   assign push_c     = last_bit_c && par_ok_c && !resync;
   assign pop_c      = word_valid && word_ready;

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state     <= HUNT;
         sync_lock <= 1'b0;
         shreg     <= '0;
         cnt       <= '0;
         overflow  <= 1'b0;
`ifdef OUT_DESER_PARITY_EN
         parity_err <= 1'b0;
`endif
      end else begin
         overflow <= push_c && full && !pop_c;
`ifdef OUT_DESER_PARITY_EN
         parity_err <= last_bit_c && !par_ok_c && !resync;
`endif
         if (resync) begin
            state     <= HUNT;
            sync_lock <= 1'b0;
            shreg     <= '0;
            cnt       <= '0;
         end else if (bit_en) begin
            case (state)
               HUNT: begin
                  shreg <= shifted_c;
                  if (shifted_c == SYNC_PATTERN) begin
                     state     <= LOCK;
                     sync_lock <= 1'b1;
                     cnt       <= '0;
                  end
               end
               LOCK: begin
                  shreg <= shifted_c;
                  if (last_bit_c) begin
                     cnt <= '0;
`ifdef OUT_DESER_PARITY_EN
                     if (!par_ok_c) begin
                        state     <= HUNT;
                        sync_lock <= 1'b0;
                        shreg     <= '0;
                     end
`endif
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               default: state <= HUNT;
            endcase
         end
      end
   end

   out_deser_fifo2 #(
      .WIDTH (WIDTH)
   ) u_fifo (
      .clk1      (clk1),
      .rst_n     (rst_n),
      .push      (push_c),
      .push_data (word_c),
      .full      (full),
      .pop       (word_ready),
      .valid     (word_valid),
      .data      (word_data)
   );

endmodule
